// File: rtl/flash_pkg.sv
// Shared flash definitions: default widths, reader FSM states,
// and flash manager mode constants used by manager clients.
package flash_pkg;

   localparam int FLASH_ADDR_W = 23;
   localparam int FLASH_DATA_W = 16;

   localparam logic WRITEMODE_READ = 1'b0;

   typedef enum logic [1:0] {
      RD_IDLE,
      RD_ISSUE,
      RD_WAIT,
      RD_ABORT
   } rd_state_e;

   typedef enum logic [1:0] {
      MGR_IDLE  = 2'd0,
      MGR_INIT  = 2'd1,
      MGR_WRITE = 2'd2,
      MGR_READ  = 2'd3
   } mgr_mode_e;

endpackage

// File: rtl/flash_stream_reader_if.sv
// Reader bus: manager read port on one side, sample
// stream towards the consumer on the other.
interface flash_stream_reader_if
   import flash_pkg::*;
#(
   parameter int ADDR_W = FLASH_ADDR_W,
   parameter int DATA_W = FLASH_DATA_W
) ();

   logic              writemode;
   logic [ADDR_W-1:0] raddr;
   logic              doread;
   logic              mgr_busy;
   logic [DATA_W-1:0] mgr_rdata;
   logic [DATA_W-1:0] sample;
   logic              sample_valid;
   logic              sample_ready;

   modport master (
      output writemode,
      output raddr,
      output doread,
      input  mgr_busy,
      input  mgr_rdata,
      output sample,
      output sample_valid,
      input  sample_ready
   );

   modport slave (
      input  writemode,
      input  raddr,
      input  doread,
      output mgr_busy,
      output mgr_rdata,
      input  sample,
      input  sample_valid,
      output sample_ready
   );

endinterface

// File: rtl/stream_fifo.sv
// Synchronous show-ahead FIFO; head word is visible while
// non-empty, flush empties it in one cycle.
module stream_fifo
   import flash_pkg::*;
#(
   parameter int DATA_W     = FLASH_DATA_W,
   parameter int FIFO_DEPTH = 8,
   localparam int PTR_W     = $clog2(FIFO_DEPTH),
   localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_push,
   input  logic [DATA_W-1:0] i_data,
   input  logic              i_pop,
   input  logic              i_flush,
   output logic [DATA_W-1:0] o_data,
   output logic [CNT_W-1:0]  o_count,
   output logic              o_empty,
   output logic              o_full
);

   logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  r_wptr;
   logic [PTR_W-1:0]  r_rptr;
   logic [CNT_W-1:0]  r_count;
   logic              w_do_push;
   logic              w_do_pop;

   assign o_empty   = (r_count == '0);
   assign o_full    = (r_count == CNT_W'(FIFO_DEPTH));
   assign o_count   = r_count;
   assign o_data    = r_mem[r_rptr];
   assign w_do_pop  = i_pop & ~o_empty;
   assign w_do_push = i_push & (~o_full | w_do_pop);

   // Storage write; contents need no reset.
   always_ff @(posedge clk) begin
      if (w_do_push && !i_flush) begin
         r_mem[r_wptr] <= i_data;
      end
   end

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk) begin
      if (rst || i_flush) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_do_push) begin
            r_wptr <= r_wptr + PTR_W'(1);
         end
         if (w_do_pop) begin
            r_rptr <= r_rptr + PTR_W'(1);
         end
         unique case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/flash_stream_reader.sv
// Streams a flash word range through the manager read port
// into a prefetch FIFO, optionally looping over the range.
module flash_stream_reader
   import flash_pkg::*;
#(
   parameter int ADDR_W     = FLASH_ADDR_W,
   parameter int DATA_W     = FLASH_DATA_W,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                start,
   input  logic                stop,
   input  logic                loop,
   input  logic [ADDR_W-1:0]   start_addr,
   input  logic [ADDR_W-1:0]   end_addr,
   output logic                active,
   output logic                done,
   flash_stream_reader_if.master bus
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   rd_state_e         r_state;
   rd_state_e         w_state_nxt;
   logic [ADDR_W-1:0] r_raddr;
   logic [ADDR_W-1:0] w_raddr_nxt;
   logic [ADDR_W-1:0] r_start;
   logic [ADDR_W-1:0] w_start_nxt;
   logic [ADDR_W-1:0] r_end;
   logic [ADDR_W-1:0] w_end_nxt;
   logic              r_loop;
   logic              w_loop_nxt;
   logic              r_pend;
   logic              w_pend_nxt;
   logic              r_done;
   logic              w_done_nxt;

   logic              w_start_ok;
   logic              w_room;
   logic              w_doread;
   logic              w_capture;
   logic              w_flush;
   logic              w_push;
   logic              w_pop;
   logic [DATA_W-1:0] w_head;
   logic [CNT_W-1:0]  w_count;
   logic              w_empty;
   logic              w_full;

   assign w_start_ok = start & (start_addr <= end_addr);
   assign w_room     = (w_count < CNT_W'(FIFO_DEPTH));
   assign w_push     = w_capture & ~w_full;
   assign w_pop      = ~w_empty & bus.sample_ready;

   assign bus.writemode    = WRITEMODE_READ;
   assign bus.raddr        = r_raddr;
   assign bus.doread       = w_doread;
   assign bus.sample       = w_head;
   assign bus.sample_valid = ~w_empty;
   assign active           = (r_state != RD_IDLE);
   assign done             = r_done;

   stream_fifo #(
      .DATA_W     (DATA_W),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clock),
      .rst     (reset),
      .i_push  (w_push),
      .i_data  (bus.mgr_rdata),
      .i_pop   (w_pop),
      .i_flush (w_flush),
      .o_data  (w_head),
      .o_count (w_count),
      .o_empty (w_empty),
      .o_full  (w_full)
   );

   // State, address and latched range registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= RD_IDLE;
         r_raddr <= '0;
         r_start <= '0;
         r_end   <= '0;
         r_loop  <= 1'b0;
         r_pend  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_raddr <= w_raddr_nxt;
         r_start <= w_start_nxt;
         r_end   <= w_end_nxt;
         r_loop  <= w_loop_nxt;
         r_pend  <= w_pend_nxt;
         r_done  <= w_done_nxt;
      end
   end

   // Next-state, read request and FIFO control decode.
   always_comb begin
      w_state_nxt = r_state;
      w_raddr_nxt = r_raddr;
      w_start_nxt = r_start;
      w_end_nxt   = r_end;
      w_loop_nxt  = r_loop;
      w_pend_nxt  = r_pend;
      w_done_nxt  = 1'b0;
      w_doread    = 1'b0;
      w_capture   = 1'b0;
      w_flush     = 1'b0;
      unique case (r_state)
         RD_IDLE: begin
            if (stop) begin
               w_pend_nxt = 1'b0;
               w_flush    = 1'b1;
            end else begin
               if (w_start_ok) begin
                  w_start_nxt = start_addr;
                  w_end_nxt   = end_addr;
                  w_loop_nxt  = loop;
                  w_pend_nxt  = 1'b1;
               end
               // A start seen while the manager is busy waits here.
               if ((w_start_ok || r_pend) && !bus.mgr_busy) begin
                  w_state_nxt = RD_ISSUE;
                  w_raddr_nxt = w_start_ok ? start_addr : r_start;
                  w_pend_nxt  = 1'b0;
                  w_flush     = 1'b1;
               end
            end
         end
         RD_ISSUE: begin
            w_doread = w_room;
            if (w_room && bus.mgr_busy) begin
               w_state_nxt = stop ? RD_ABORT : RD_WAIT;
               w_flush     = stop;
            end else if (stop) begin
               w_state_nxt = RD_IDLE;
               w_flush     = 1'b1;
            end
         end
         RD_WAIT: begin
            if (stop) begin
               w_state_nxt = RD_ABORT;
               w_flush     = 1'b1;
            end else if (!bus.mgr_busy) begin
               w_capture = 1'b1;
               if (r_raddr == r_end) begin
                  if (r_loop) begin
                     w_raddr_nxt = r_start;
                     w_state_nxt = RD_ISSUE;
                  end else begin
                     w_done_nxt  = 1'b1;
                     w_state_nxt = RD_IDLE;
                  end
               end else begin
                  w_raddr_nxt = r_raddr + ADDR_W'(1);
                  w_state_nxt = RD_ISSUE;
               end
            end
         end
         RD_ABORT: begin
            // The in-flight word is dropped once the manager settles.
            if (!bus.mgr_busy) begin
               w_state_nxt = RD_IDLE;
               w_flush     = 1'b1;
            end
         end
         default: w_state_nxt = RD_IDLE;
      endcase
   end

endmodule

// File: tb/tb_flash_stream_reader.sv
// Bench for flash_stream_reader: manager model, queue-based
// expectation model and per-cycle compare process.
module tb_flash_stream_reader;
   import flash_pkg::*;

   localparam int AW    = 23;
   localparam int DW    = 16;
   localparam int DEPTH = 8;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic          stop  = 1'b0;
   logic          loop  = 1'b0;
   logic [AW-1:0] start_addr = '0;
   logic [AW-1:0] end_addr   = '0;
   logic          active;
   logic          done;

   flash_stream_reader_if #(.ADDR_W(AW), .DATA_W(DW)) bus_if ();

   flash_stream_reader #(
      .ADDR_W     (AW),
      .DATA_W     (DW),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .start      (start),
      .stop       (stop),
      .loop       (loop),
      .start_addr (start_addr),
      .end_addr   (end_addr),
      .active     (active),
      .done       (done),
      .bus        (bus_if.master)
   );

   always #5 clock = ~clock;

   // Manager: busy one cycle after doread, held 5 cycles.
   logic          m_busy = 1'b0;
   logic [DW-1:0] m_data = '0;
   int            m_cnt  = 0;

   assign bus_if.mgr_busy  = m_busy;
   assign bus_if.mgr_rdata = m_data;

   always @(posedge clock) begin
      if (m_busy) begin
         if (m_cnt == 1) m_busy <= 1'b0;
         m_cnt <= m_cnt - 1;
      end else if (bus_if.doread) begin
         m_busy <= 1'b1;
         m_cnt  <= 5;
         m_data <= bus_if.raddr[15:0] ^ 16'hA5A5;
      end
   end

   logic [AW-1:0] exp_addr_q [$];
   logic [DW-1:0] exp_data_q [$];
   logic [DW-1:0] got_q [$];
   int n_tests = 0;
   int n_fail  = 0;
   int n_reads = 0;
   int n_done  = 0;
   bit mon_en  = 1'b0;

   task automatic check(input string name,
                        input logic [63:0] act,
                        input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   // Compare process: every accepted read and every popped word.
   always @(negedge clock) begin
      logic [AW-1:0] a;
      if (mon_en) begin
         check("writemode", bus_if.writemode, 0);
         if (bus_if.doread && !bus_if.mgr_busy) begin
            n_reads++;
            if (exp_addr_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_read: got raddr %0h required none",
                        bus_if.raddr);
            end else begin
               a = exp_addr_q.pop_front();
               check("raddr", bus_if.raddr, a);
               exp_data_q.push_back(a[15:0] ^ 16'hA5A5);
            end
         end
         if (bus_if.sample_valid && bus_if.sample_ready) begin
            got_q.push_back(bus_if.sample);
            if (exp_data_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_sample: got %0h required none",
                        bus_if.sample);
            end else begin
               check("sample", bus_if.sample, exp_data_q.pop_front());
            end
         end
         if (done) n_done++;
      end
   end

   task automatic pulse_start(input logic [AW-1:0] sa,
                              input logic [AW-1:0] ea,
                              input logic lp);
      @(posedge clock); #1;
      start      = 1'b1;
      start_addr = sa;
      end_addr   = ea;
      loop       = lp;
      @(posedge clock); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int max, input string name);
      bit seen = 1'b0;
      for (int i = 0; i < max; i++) begin
         @(negedge clock);
         if (done) begin
            seen = 1'b1;
            break;
         end
      end
      n_tests++;
      if (!seen) begin
         n_fail++;
         $display("FAIL %s: got no done within %0d cycles required one",
                  name, max);
      end
   endtask

   task automatic wait_idle(input int max, input string name);
      bit seen = 1'b0;
      for (int i = 0; i < max; i++) begin
         @(negedge clock);
         if (!active) begin
            seen = 1'b1;
            break;
         end
      end
      n_tests++;
      if (!seen) begin
         n_fail++;
         $display("FAIL %s: got active=1 after %0d cycles required 0",
                  name, max);
      end
   endtask

   task automatic wait_reads(input int base, input int want,
                             input int max, input string name);
      bit seen = 1'b0;
      for (int i = 0; i < max; i++) begin
         @(negedge clock);
         if (n_reads - base >= want) begin
            seen = 1'b1;
            break;
         end
      end
      n_tests++;
      if (!seen) begin
         n_fail++;
         $display("FAIL %s: got %0d reads required %0d",
                  name, n_reads - base, want);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int r0;
      int d0;
      bus_if.sample_ready = 1'b1;

      repeat (3) @(posedge clock);
      #1;
      check("rst_doread", bus_if.doread, 0);
      check("rst_raddr", bus_if.raddr, 0);
      check("rst_writemode", bus_if.writemode, 0);
      check("rst_valid", bus_if.sample_valid, 0);
      check("rst_active", active, 0);
      check("rst_done", done, 0);
      reset  = 1'b0;
      mon_en = 1'b1;

      // Range 0x10..0x13, consumer always ready.
      for (int i = 'h10; i <= 'h13; i++) exp_addr_q.push_back(AW'(i));
      got_q.delete();
      d0 = n_done;
      pulse_start(23'h10, 23'h13, 1'b0);
      check("t1_doread_t1", bus_if.doread, 1);
      check("t1_active", active, 1);
      check("t1_raddr", bus_if.raddr, 23'h10);
      wait_done(200, "t1_done");
      check("t1_active_at_done", active, 0);
      check("t1_valid_at_done", bus_if.sample_valid, 1);
      repeat (5) @(negedge clock);
      check("t1_done_cnt", n_done - d0, 1);
      check("t1_words", got_q.size(), 4);
      if (got_q.size() == 4) begin
         check("t1_w0", got_q[0], 16'hA5B5);
         check("t1_w1", got_q[1], 16'hA5B4);
         check("t1_w2", got_q[2], 16'hA5B7);
         check("t1_w3", got_q[3], 16'hA5B6);
      end

      // Backpressure: range 0..15 with consumer stalled.
      @(posedge clock); #1;
      bus_if.sample_ready = 1'b0;
      got_q.delete();
      r0 = n_reads;
      for (int i = 0; i <= 15; i++) exp_addr_q.push_back(AW'(i));
      pulse_start(23'h0, 23'hF, 1'b0);
      repeat (120) @(negedge clock);
      check("t2_reads_full", n_reads - r0, DEPTH);
      check("t2_doread_full", bus_if.doread, 0);
      check("t2_valid_full", bus_if.sample_valid, 1);
      check("t2_head", bus_if.sample, 16'hA5A5);
      check("t2_active_full", active, 1);
      @(posedge clock); #1;
      bus_if.sample_ready = 1'b1;
      wait_done(400, "t2_done");
      repeat (20) @(negedge clock);
      check("t2_words", got_q.size(), 16);
      check("t2_reads", n_reads - r0, 16);
      check("t2_drained", exp_data_q.size(), 0);

      // Loop 5..6, then stop while a read is outstanding.
      got_q.delete();
      r0 = n_reads;
      d0 = n_done;
      for (int i = 0; i < 4; i++) begin
         exp_addr_q.push_back(23'h5);
         exp_addr_q.push_back(23'h6);
      end
      pulse_start(23'h5, 23'h6, 1'b1);
      wait_reads(r0, 5, 200, "t3_reads");
      repeat (3) @(posedge clock);
      #1;
      stop = 1'b1;
      @(posedge clock); #1;
      stop = 1'b0;
      exp_addr_q.delete();
      exp_data_q.delete();
      check("t3_valid_stop", bus_if.sample_valid, 0);
      check("t3_doread_stop", bus_if.doread, 0);
      check("t3_active_abort", active, 1);
      wait_idle(20, "t3_idle");
      repeat (15) @(negedge clock);
      check("t3_reads", n_reads - r0, 5);
      check("t3_no_done", n_done - d0, 0);
      check("t3_words", got_q.size(), 4);
      if (got_q.size() == 4) begin
         check("t3_w0", got_q[0], 16'hA5A0);
         check("t3_w1", got_q[1], 16'hA5A3);
         check("t3_w2", got_q[2], 16'hA5A0);
      end

      // Inverted range is ignored.
      r0 = n_reads;
      d0 = n_done;
      pulse_start(23'h7, 23'h3, 1'b0);
      check("t4_doread_inv", bus_if.doread, 0);
      check("t4_active_inv", active, 0);
      repeat (15) @(negedge clock);
      check("t4_reads_inv", n_reads - r0, 0);
      check("t4_done_inv", n_done - d0, 0);

      // Second start while active is ignored.
      got_q.delete();
      exp_addr_q.push_back(23'h20);
      exp_addr_q.push_back(23'h21);
      pulse_start(23'h20, 23'h21, 1'b0);
      repeat (3) @(posedge clock);
      pulse_start(23'h40, 23'h50, 1'b0);
      wait_done(200, "t4_done");
      repeat (15) @(negedge clock);
      check("t4_reads", n_reads - r0, 2);
      check("t4_done_cnt", n_done - d0, 1);
      check("t4_words", got_q.size(), 2);

      // Top-of-space single word: no wrap.
      got_q.delete();
      r0 = n_reads;
      exp_addr_q.push_back(23'h7FFFFF);
      pulse_start(23'h7FFFFF, 23'h7FFFFF, 1'b0);
      wait_done(200, "t5_done");
      repeat (20) @(negedge clock);
      check("t5_reads", n_reads - r0, 1);
      check("t5_raddr", bus_if.raddr, 23'h7FFFFF);
      check("t5_active", active, 0);
      check("t5_words", got_q.size(), 1);
      if (got_q.size() == 1) check("t5_w0", got_q[0], 16'h5A5A);

      // Reset while a request is raised.
      for (int i = 0; i <= 3; i++) exp_addr_q.push_back(AW'(i));
      pulse_start(23'h0, 23'h3, 1'b0);
      check("t6_doread_pre", bus_if.doread, 1);
      reset = 1'b1;
      @(posedge clock); #1;
      check("t6_doread", bus_if.doread, 0);
      check("t6_valid", bus_if.sample_valid, 0);
      check("t6_active", active, 0);
      check("t6_done", done, 0);
      reset = 1'b0;
      exp_addr_q.delete();
      exp_data_q.delete();
      repeat (10) @(negedge clock);
      check("t6_idle_doread", bus_if.doread, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
